// File: rtl/rr_grant_arbiter_if.sv
// Requester <-> arbiter handshake bundle for rr_grant_arbiter.
// master: requester side (drives req). slave: arbiter side (drives grant info).
interface rr_grant_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           timeout_pulse;

  modport master (output req, input grant, grant_valid, grant_id, timeout_pulse);
  modport slave  (input req, output grant, grant_valid, grant_id, timeout_pulse);
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin, hold-until-release arbiter for one shared resource.
// Optional feature: define ARB_TIMEOUT_EN to force-release an owner that holds
// the grant for MAX_HOLD cycles (timeout_pulse marks the forced handoff).
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_grant_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_last;
  logic [N-1:0]   r_grant;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic [CW-1:0]  r_cnt;
  logic           r_tpulse;

  logic           w_found;
  logic [IDW-1:0] w_win;

  // Cyclic search starting just after the last winner. While OWNED, r_last is
  // the owner, so the owner itself is examined last: it only wins again when
  // nobody else is requesting (used by the timeout re-grant).
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 1; i <= N; i++) begin
      if (!w_found && bus.req[(int'(r_last) + i) % N]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_last) + i) % N);
      end
    end
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= IDW'(N - 1);
      r_grant  <= '0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_tpulse <= 1'b0;
    end else begin
      r_tpulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= OWNED;
            r_last  <= w_win;
            r_grant <= N'(1) << w_win;
            r_valid <= 1'b1;
            r_id    <= w_win;
            r_cnt   <= '0;
          end
        end
        OWNED: begin
          if (!bus.req[r_id]) begin
            // Voluntary release: hand off directly, or fall back to idle.
            if (w_found) begin
              r_last  <= w_win;
              r_grant <= N'(1) << w_win;
              r_id    <= w_win;
              r_cnt   <= '0;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
              r_valid <= 1'b0;
              r_id    <= '0;
              r_cnt   <= '0;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt == CW'(MAX_HOLD - 1)) begin
            // Forced release; owner is still requesting so w_found is set
            // (possibly the owner itself when nobody else waits).
            r_tpulse <= 1'b1;
            r_last   <= w_win;
            r_grant  <= N'(1) << w_win;
            r_id     <= w_win;
            r_cnt    <= '0;
          end
`endif
          else if (r_cnt < CW'(MAX_HOLD)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant         = r_grant;
  assign bus.grant_valid   = r_valid;
  assign bus.grant_id      = r_id;
  assign bus.timeout_pulse = r_tpulse;

endmodule
